// File: rtl/rv_pkg.sv
// ============================================================================
// Module : rv_pkg
// Brief  : Shared RISC-V core constants and types.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } iccm_state_t;

endpackage

`default_nettype wire

// File: rtl/iccm_ram_1r1w.sv
// ============================================================================
// Module : iccm_ram_1r1w
// Brief  : 32-bit wide 1R1W RAM, synchronous read-first, byte-masked write.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iccm_ram_1r1w #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb
);

    logic [31:0] mem [DEPTH];

    // Read and write share one process so a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/iccm.sv
// ============================================================================
// Module : iccm
// Brief  : Instruction CCM: 1-cycle fetch read port, handshaked loader write
//          port, NOP fill after reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iccm
    import rv_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] INIT_WORD = RV_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iccm_rd_en,
    input  logic [31:0] iccm_rd_addr,
    output logic [31:0] iccm_rd_data,
    output logic        rd_err,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic        wr_err,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH);

    iccm_state_t   state_q;
    iccm_state_t   state_d;
    logic [AW-1:0] cnt_q;

    logic          rd_bad_range;
    logic          rd_bad_align;
    logic          wr_bad;
    logic          wr_accept;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_strb;
    logic [31:0]   ram_rdata;

    logic          rd_valid_q;
    logic          rd_init_q;
    logic          rd_err_q;
    logic          wr_err_q;

    assign rd_bad_range = |iccm_rd_addr[31:AW+2];
    assign rd_bad_align = |iccm_rd_addr[1:0];
    assign wr_bad       = (|wr_addr[31:AW+2]) || (|wr_addr[1:0]);
    assign wr_accept    = wr_valid && wr_ready;

    assign wr_ready  = (state_q == RUN);
    assign init_done = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && cnt_q == AW'(DEPTH - 1)) begin
            state_d = RUN;
        end
    end

    // Init fill owns the write port until RUN; the loader is locked out by wr_ready.
    always_comb begin
        ram_we    = wr_accept && !wr_bad;
        ram_waddr = wr_addr[AW+1:2];
        ram_wdata = wr_data;
        ram_strb  = wr_strb;
        if (state_q == INIT) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = INIT_WORD;
            ram_strb  = 4'hF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_init_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_err_q <= wr_accept && wr_bad;
            if (state_q == INIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (iccm_rd_en) begin
                rd_valid_q <= 1'b1;
                rd_init_q  <= (state_q == INIT) || rd_bad_range;
                rd_err_q   <= (state_q == RUN) && (rd_bad_range || rd_bad_align);
            end
        end
    end

    iccm_ram_1r1w #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rd_en   (iccm_rd_en),
        .rd_addr (iccm_rd_addr[AW+1:2]),
        .rd_data (ram_rdata),
        .we      (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .wr_strb (ram_strb)
    );

    // The RAM read register holds when idle, so the select flags make the whole path hold too.
    assign iccm_rd_data = !rd_valid_q ? 32'h0 : (rd_init_q ? INIT_WORD : ram_rdata);
    assign rd_err       = rd_err_q;
    assign wr_err       = wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_iccm.sv
// ============================================================================
// Module : tb_iccm
// Brief  : Directed self-checking bench for iccm (DEPTH = 16).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iccm;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iccm_rd_en;
    logic [31:0] iccm_rd_addr;
    logic [31:0] iccm_rd_data;
    logic        rd_err;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_err;
    logic        init_done;

    int n_tests = 0;
    int n_fail  = 0;

    iccm #(
        .DEPTH     (16),
        .INIT_WORD (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iccm_rd_en   (iccm_rd_en),
        .iccm_rd_addr (iccm_rd_addr),
        .iccm_rd_data (iccm_rd_data),
        .rd_err       (rd_err),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .wr_err       (wr_err),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_strb  = s;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        iccm_rd_en   = 1'b1;
        iccm_rd_addr = a;
        tick();
        iccm_rd_en = 1'b0;
    endtask

    initial begin
        int cyc;
        rst_n        = 1'b0;
        iccm_rd_en   = 1'b0;
        iccm_rd_addr = 32'h0;
        wr_valid     = 1'b0;
        wr_addr      = 32'h0;
        wr_data      = 32'h0;
        wr_strb      = 4'h0;
        tick();
        tick();
        check("rst_rd_data", iccm_rd_data, 32'h0);
        check("rst_rd_err", {31'h0, rd_err}, 32'h0);
        check("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
        check("rst_wr_err", {31'h0, wr_err}, 32'h0);
        check("rst_init_done", {31'h0, init_done}, 32'h0);

        // Release reset with the loader pushing and an out-of-range read pending.
        wr_valid     = 1'b1;
        wr_strb      = 4'hF;
        iccm_rd_en   = 1'b1;
        iccm_rd_addr = 32'h44;
        rst_n        = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 1) begin
                check("init_rd_data", iccm_rd_data, NOP);
                check("init_rd_err", {31'h0, rd_err}, 32'h0);
                iccm_rd_en = 1'b0;
            end
            check("init_wr_ready", {31'h0, wr_ready}, 32'h0);
            check("init_done_low", {31'h0, init_done}, 32'h0);
        end
        tick();
        wr_valid = 1'b0;
        check("edge16_wr_ready", {31'h0, wr_ready}, 32'h1);
        check("edge16_init_done", {31'h0, init_done}, 32'h1);

        do_read(32'h8);
        check("rd_0x8", iccm_rd_data, NOP);
        check("rd_0x8_err", {31'h0, rd_err}, 32'h0);

        do_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        check("wr_ok_err", {31'h0, wr_err}, 32'h0);
        do_read(32'h10);
        check("rd_0x10", iccm_rd_data, 32'hDEAD_BEEF);

        do_write(32'h4, 32'h0000_0004, 4'hF);
        iccm_rd_en   = 1'b1;
        iccm_rd_addr = 32'h0;
        tick();
        check("stream_0x0", iccm_rd_data, NOP);
        iccm_rd_addr = 32'h4;
        tick();
        check("stream_0x4", iccm_rd_data, 32'h0000_0004);
        iccm_rd_addr = 32'h10;
        tick();
        check("stream_0x10", iccm_rd_data, 32'hDEAD_BEEF);
        iccm_rd_en = 1'b0;
        tick();
        check("hold_data", iccm_rd_data, 32'hDEAD_BEEF);

        do_write(32'h8, 32'h1122_3344, 4'b0101);
        do_read(32'h8);
        check("strobe_0101", iccm_rd_data, 32'h0022_0044);

        do_write(32'h20, 32'hAAAA_5555, 4'hF);
        wr_valid     = 1'b1;
        wr_addr      = 32'h20;
        wr_data      = 32'h1234_5678;
        wr_strb      = 4'hF;
        iccm_rd_en   = 1'b1;
        iccm_rd_addr = 32'h20;
        tick();
        wr_valid   = 1'b0;
        iccm_rd_en = 1'b0;
        check("collide_old", iccm_rd_data, 32'hAAAA_5555);
        do_read(32'h20);
        check("collide_new", iccm_rd_data, 32'h1234_5678);

        do_read(32'h40);
        check("oor_rd_data", iccm_rd_data, NOP);
        check("oor_rd_err", {31'h0, rd_err}, 32'h1);
        do_read(32'h6);
        check("mis_rd_data", iccm_rd_data, 32'h0000_0004);
        check("mis_rd_err", {31'h0, rd_err}, 32'h1);
        tick();
        check("hold_err", {31'h0, rd_err}, 32'h1);

        do_write(32'h44, 32'hFFFF_FFFF, 4'hF);
        check("oor_wr_err", {31'h0, wr_err}, 32'h1);
        tick();
        check("oor_wr_err_pulse", {31'h0, wr_err}, 32'h0);
        do_write(32'h6, 32'hFFFF_FFFF, 4'hF);
        check("mis_wr_err", {31'h0, wr_err}, 32'h1);
        do_write(32'h4, 32'hFFFF_FFFF, 4'h0);
        check("strb0_wr_err", {31'h0, wr_err}, 32'h0);
        do_read(32'h4);
        check("wr_dropped", iccm_rd_data, 32'h0000_0004);
        check("wr_dropped_err", {31'h0, rd_err}, 32'h0);

        do_write(32'h0, 32'hCAFE_F00D, 4'hF);
        iccm_rd_en   = 1'b1;
        iccm_rd_addr = 32'h0;
        tick();
        check("pre_rst_rd", iccm_rd_data, 32'hCAFE_F00D);
        rst_n = 1'b0;
        #1;
        check("async_rst_rd_data", iccm_rd_data, 32'h0);
        check("async_rst_init_done", {31'h0, init_done}, 32'h0);
        check("async_rst_wr_ready", {31'h0, wr_ready}, 32'h0);
        tick();
        iccm_rd_en = 1'b0;
        rst_n      = 1'b1;
        cyc        = 0;
        while (!init_done && cyc < 40) begin
            tick();
            cyc++;
        end
        check("reinit_edges", cyc, 16);
        do_read(32'h0);
        check("reinit_rd_0x0", iccm_rd_data, NOP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iccm.md
# iccm

Instruction closely-coupled memory: the responder for the fetch unit's ICCM read port, plus a handshaked write port for program loading.
- Serves one 32-bit word per cycle with fixed one-cycle read latency, matching the fetch pipeline's one-stage address-to-data delay.
- After reset, fills every word with a NOP before accepting writes.
- Sits between the fetch unit and the program loader/debug path.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, >= 4. AW = $clog2(DEPTH).
- INIT_WORD, 32'h0000_0013: fill value written at init (RV32I NOP, `addi x0,x0,0`).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- iccm_rd_en  in  1  read request this cycle.
- iccm_rd_addr  in  32  byte address of the instruction word.
- iccm_rd_data  out  32  word for the address presented the previous cycle.
- rd_err  out  1  registered with iccm_rd_data; set when the read address was out of range or misaligned.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  32  byte address of the word to write.
- wr_data  in  32  write data.
- wr_strb  in  4  byte enables; bit i enables byte lane [8i+7:8i].
- wr_err  out  1  one-cycle pulse, the cycle after an accepted write to an out-of-range or misaligned address.
- init_done  out  1  high once the init fill has completed.

## Operation
- Reset values: iccm_rd_data 0, rd_err 0, wr_ready 0, wr_err 0, init_done 0, state INIT, init counter 0.
- Address decode applies to both ports:
  - Word index = addr[AW+1:2].
  - Out of range when addr[31:AW+2] != 0.
  - Misaligned when addr[1:0] != 0.
- FSM has two states, INIT and RUN.
- INIT:
  - Writes INIT_WORD to word[cnt] each cycle; cnt counts 0..DEPTH-1.
  - When cnt == DEPTH-1 the FSM moves to RUN.
  - wr_ready is 0.
  - Reads return INIT_WORD with rd_err 0, regardless of address.
- RUN:
  - wr_ready is held at 1, so no backpressure.
  - init_done is 1.
  - The FSM stays in RUN until reset.
- Read with iccm_rd_en = 1:
  - Next cycle, iccm_rd_data = word[index] and rd_err = (out of range || misaligned).
  - Out-of-range reads return INIT_WORD.
  - Misaligned reads return word[index]; low address bits are ignored.
- Read with iccm_rd_en = 0: iccm_rd_data and rd_err hold their previous values.
- Accepted write:
  - In range and aligned: byte lanes with wr_strb[i] = 1 are updated; other lanes are kept.
  - Out of range or misaligned: the write is dropped and wr_err pulses.
  - wr_strb = 0 is legal; nothing changes and wr_err is not raised.
- Same-cycle read and write to the same word is read-first: iccm_rd_data returns the old word, and the following read returns the new word.
- Reset asserted mid-operation, including mid-INIT:
  - All outputs take their reset values immediately.
  - After release, a full re-fill runs; contents from before the reset are not preserved.

## Timing
- Read latency is exactly 1 cycle: address at edge N, data valid after edge N+1. Read throughput is 1 word per cycle, including back-to-back reads and reads during writes.
- Write takes effect at the accepting edge and is visible to a read issued on the next cycle.
- init_done rises at the DEPTH-th rising edge after rst_n deassertion. wr_ready rises in the same cycle.
- wr_err is asserted for exactly one cycle per offending accepted write.

## Structure
- Shared package rv_pkg holds:
  - RV_NOP = 32'h0000_0013, the default for INIT_WORD.
  - iccm_state_t, an enum {INIT, RUN}.
- Sub-module iccm_ram_1r1w (DEPTH, 32-bit, 4 byte enables):
  - Synchronous read-first read port and byte-masked write port.
  - No reset on the array.
- Top level holds the FSM, init counter, address decode, write muxing (init fill vs. loader) and the output registers.

## Test plan
- Bench uses DEPTH = 16.
- Reset and init: release rst_n, hold wr_valid = 1 → wr_ready = 0 and init_done = 0 for 15 cycles; both rise at edge 16. A read of 0x8 returns 32'h0000_0013 with rd_err = 0.
- Basic write then read:
  - Stimulus: after init, write 32'hDEAD_BEEF to 0x10 with strb 4'hF, then read 0x10.
  - Response: 32'hDEAD_BEEF one cycle after the read request.
  - Stimulus: back-to-back reads of 0x0, 0x4, 0x10.
  - Response: data streams one word per cycle.
- Byte strobes: write 32'h1122_3344 with strb 4'b0101 to a word holding 32'h0000_0013 → the word reads back 32'h0022_0044.
- Collision: word 0x20 holds 32'hAAAA_5555; in the same cycle, write 32'h1234_5678 to 0x20 and read 0x20 → iccm_rd_data = 32'hAAAA_5555. The next read returns 32'h1234_5678.
- Errors:
  - Read 0x40 → 32'h0000_0013 with rd_err = 1.
  - Read 0x6 → word[1] with rd_err = 1.
  - Write 0x44 → wr_err pulses for one cycle and memory is unchanged.
- Reset mid-operation:
  - Stimulus: write 0x0 = 32'hCAFE_F00D, then assert rst_n for 1 cycle during a read stream.
  - Response: iccm_rd_data goes to 0 and init_done goes to 0 immediately. After re-init, 0x0 reads 32'h0000_0013.
